// File: rtl/ramio_arbiter_pkg.sv
// rtl/ramio_arbiter_pkg.sv - shared types and ramio read/write type encodings
package ramio_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Read type: [1:0] access size, [2] sign-extend.
  localparam logic [2:0] RT_NONE     = 3'b000;
  localparam logic [2:0] RT_BYTE     = 3'b001;
  localparam logic [2:0] RT_HALF     = 3'b010;
  localparam logic [2:0] RT_WORD     = 3'b011;
  localparam int         RT_SIGN_BIT = 2;

  // Write type: access size only.
  localparam logic [1:0] WT_NONE = 2'b00;
  localparam logic [1:0] WT_BYTE = 2'b01;
  localparam logic [1:0] WT_HALF = 2'b10;
  localparam logic [1:0] WT_WORD = 2'b11;

  function automatic logic is_read(input logic [2:0] rt);
    return rt != RT_NONE;
  endfunction

  function automatic logic is_write(input logic [1:0] wt);
    return wt != WT_NONE;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_o
);

  // On a tie the port that did not win last time goes next; otherwise the sole requester.
  always_comb begin
    valid_o = |req_i;
    if (&req_i) grant_o = ~last_grant_i;
    else        grant_o = req_i[1];
  end

endmodule

// File: rtl/ramio_arbiter.sv
// rtl/ramio_arbiter.sv - two-port arbiter/sequencer in front of the ramio interface
module ramio_arbiter
  import ramio_arbiter_pkg::*;
#(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32,
  parameter int TimeoutCycles   = 4096,
  parameter int TimeoutBitWidth = $clog2(TimeoutCycles + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       p0_req,
  input  logic [2:0]                 p0_read_type,
  input  logic [1:0]                 p0_write_type,
  input  logic [AddressBitWidth-1:0] p0_address,
  input  logic [DataBitWidth-1:0]    p0_data_in,
  output logic [DataBitWidth-1:0]    p0_data_out,
  output logic                       p0_ack,
  output logic                       p0_error,
  input  logic                       p1_req,
  input  logic [2:0]                 p1_read_type,
  input  logic [1:0]                 p1_write_type,
  input  logic [AddressBitWidth-1:0] p1_address,
  input  logic [DataBitWidth-1:0]    p1_data_in,
  output logic [DataBitWidth-1:0]    p1_data_out,
  output logic                       p1_ack,
  output logic                       p1_error,
  output logic                       mem_enable,
  output logic [2:0]                 mem_read_type,
  output logic [1:0]                 mem_write_type,
  output logic [AddressBitWidth-1:0] mem_address,
  output logic [DataBitWidth-1:0]    mem_data_in,
  input  logic [DataBitWidth-1:0]    mem_data_out,
  input  logic                       mem_data_out_ready,
  input  logic                       mem_busy,
  output logic                       grant_id
);

  localparam logic [TimeoutBitWidth-1:0] WD_LAST = TimeoutBitWidth'(TimeoutCycles - 1);
  localparam logic [TimeoutBitWidth-1:0] WD_ONE  = TimeoutBitWidth'(1);

  arb_state_e                 state_q, state_d;
  logic                       mem_enable_q, mem_enable_d;
  logic [2:0]                 mem_rt_q, mem_rt_d;
  logic [1:0]                 mem_wt_q, mem_wt_d;
  logic [AddressBitWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataBitWidth-1:0]    mem_wdata_q, mem_wdata_d;
  logic                       grant_q, grant_d;
  logic [TimeoutBitWidth-1:0] wd_q, wd_d;
  logic                       p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic                       p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [DataBitWidth-1:0]    p0_dout_q, p0_dout_d, p1_dout_q, p1_dout_d;

  logic arb_valid, arb_grant, done;

  rr_arbiter2 u_rr (
    .req_i        ({p1_req, p0_req}),
    .last_grant_i (grant_q),
    .valid_o      (arb_valid),
    .grant_o      (arb_grant)
  );

  // A transfer with no read data to wait for finishes as soon as downstream is not busy.
  assign done = !mem_busy && (is_write(mem_wt_q) || !is_read(mem_rt_q) || mem_data_out_ready);

  // Next-state and registered-output logic of the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_rt_d     = mem_rt_q;
    mem_wt_d     = mem_wt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p0_err_d     = 1'b0;
    p1_err_d     = 1'b0;
    p0_dout_d    = p0_dout_q;
    p1_dout_d    = p1_dout_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          mem_rt_d     = arb_grant ? p1_read_type  : p0_read_type;
          mem_wt_d     = arb_grant ? p1_write_type : p0_write_type;
          mem_addr_d   = arb_grant ? p1_address    : p0_address;
          mem_wdata_d  = arb_grant ? p1_data_in    : p0_data_in;
          mem_enable_d = 1'b1;
          grant_d      = arb_grant;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          if (is_read(mem_rt_q)) begin
            if (grant_q) p1_dout_d = mem_data_out;
            else         p0_dout_d = mem_data_out;
          end
          p0_ack_d     = !grant_q;
          p1_ack_d     = grant_q;
          mem_enable_d = 1'b0;
          state_d      = ST_RELEASE;
        end else if (wd_q == WD_LAST) begin
          if (grant_q) p1_dout_d = '1;
          else         p0_dout_d = '1;
          p0_ack_d     = !grant_q;
          p1_ack_d     = grant_q;
          p0_err_d     = !grant_q;
          p1_err_d     = grant_q;
          mem_enable_d = 1'b0;
          state_d      = ST_RELEASE;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_rt_q     <= '0;
      mem_wt_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      grant_q      <= 1'b1;
      wd_q         <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_dout_q    <= '0;
      p1_dout_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_rt_q     <= mem_rt_d;
      mem_wt_q     <= mem_wt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      grant_q      <= grant_d;
      wd_q         <= wd_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
      p0_dout_q    <= p0_dout_d;
      p1_dout_q    <= p1_dout_d;
    end
  end

  assign mem_enable     = mem_enable_q;
  assign mem_read_type  = mem_rt_q;
  assign mem_write_type = mem_wt_q;
  assign mem_address    = mem_addr_q;
  assign mem_data_in    = mem_wdata_q;
  assign grant_id       = grant_q;
  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign p0_error       = p0_err_q;
  assign p1_error       = p1_err_q;
  assign p0_data_out    = p0_dout_q;
  assign p1_data_out    = p1_dout_q;

endmodule

// File: doc/ramio_arbiter.md
Name: ramio_arbiter

Overview:
Two-port arbiter and sequencer in front of the RAM/UART/LED I/O interface; shares it between the CPU instruction-fetch port (port 0) and load/store port (port 1).
Accepts one request at a time and drives a registered, stable transaction downstream. Waits for busy/data-ready, then returns data with a one-cycle ack to the winning requester.
Round-robin arbitration with a per-transaction timeout watchdog.

Parameters:
AddressBitWidth, 32, byte address width on both sides
DataBitWidth, 32, data width on both sides
TimeoutCycles, 4096, max cycles in WAIT before forced completion with error; must be >= 2
TimeoutBitWidth, $clog2(TimeoutCycles+1), watchdog counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
p0_req  in  1  port 0 request; fields held stable until p0_ack
p0_read_type  in  3  read type, same encoding as downstream
p0_write_type  in  2  write type, same encoding as downstream
p0_address  in  AddressBitWidth  byte address
p0_data_in  in  DataBitWidth  write data
p0_data_out  out  DataBitWidth  read data, valid when p0_ack
p0_ack  out  1  one-cycle completion pulse
p0_error  out  1  valid with p0_ack: timeout occurred
p1_*  same set as p0_* for port 1
mem_enable  out  1  downstream enable
mem_read_type  out  3  downstream read type
mem_write_type  out  2  downstream write type
mem_address  out  AddressBitWidth  downstream address
mem_data_in  out  DataBitWidth  downstream write data
mem_data_out  in  DataBitWidth  downstream read data
mem_data_out_ready  in  1  downstream read data valid
mem_busy  in  1  downstream busy
grant_id  out  1  port owning current/last transaction (debug)

Behaviour:
- Reset: state IDLE, all mem_* outputs 0, p*_ack 0, p*_error 0, p*_data_out 0, grant_id 1 (so port 0 wins first tie), watchdog 0.
- All outputs registered.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - Any req: pick winner; if both request, choose the port != grant_id (round-robin), else the sole requester.
  - Latch winner's fields into mem_*; set mem_enable=1 and grant_id=winner; go to ISSUE.
- ISSUE: exactly one cycle. mem_* held; completion is not sampled, to give downstream one cycle to raise busy. Go to WAIT; watchdog=0.
- WAIT: mem_* held, watchdog increments each cycle.
  - Complete when !mem_busy and (mem_write_type!=0 or mem_data_out_ready).
  - On complete: capture mem_data_out into winner's p*_data_out if read_type!=0 (unchanged otherwise); pulse winner's p*_ack next cycle with error=0; mem_enable=0; go to RELEASE.
  - If watchdog reaches TimeoutCycles-1 without completion: ack with error=1, p*_data_out=all ones; mem_enable=0; go to RELEASE.
- RELEASE: one idle cycle with mem_enable=0 so downstream sees a new transaction edge. p*_ack is high in this cycle only. Go to IDLE.
- Latency: req sampled high in cycle N -> mem_enable high N+1 -> earliest ack N+3 (I/O addresses, never busy) -> next issue earliest N+5.
- Requester must drop req or present a new request in the ack cycle. A req still high in IDLE after RELEASE is treated as a new request.
- Dropping req mid-transaction: transaction still completes and ack is still pulsed; it is not cancelled.
- Both req held continuously: strict alternation 0,1,0,1...
- Request with read_type==0 and write_type==0: issued anyway; completes when !mem_busy.
- Reset mid-transaction: immediate return to reset values; no ack; the in-flight downstream op is abandoned.
- Never two acks in the same cycle; never an ack to a non-granted port.

Decomposition:
- Package ramio_arbiter_pkg: state enum (IDLE, ISSUE, WAIT, RELEASE) and read/write type encoding constants (byte/half/word, sign bit), shared with ramio users.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from req[1:0] and last grant.

Test Plan:
- p0 read_type=3'b111 at 0x0000_0100; mem_busy high 5 cycles, then mem_data_out=0xDEADBEEF with ready -> p0_ack once, p0_data_out=0xDEADBEEF, p0_error=0, p1_ack never.
- p0 and p1 request in the same cycle after reset -> p0 served first, then p1; held continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- p1 write_type=2'b11 to 0xFFFF_FFFC, data 0x5, mem_busy never high -> mem_enable high exactly 2 cycles, p1_ack 3 cycles after req, mem_data_in=0x5.
- TimeoutCycles=16, mem_busy stuck high -> p0_ack with p0_error=1 and p0_data_out=0xFFFF_FFFF; next request issues normally.
- rst_n low in WAIT -> next cycle mem_enable=0, no ack, grant_id=1; request after reset completes normally.
- p1 drops req in WAIT -> p1_ack still pulses; mem_enable low for exactly one RELEASE cycle between back-to-back transactions.
